// File: rtl/sum_ascii_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sum_ascii_tx
// Description : Converts the 6-bit adder result {C5,S} (0..63) to decimal
//               ASCII and streams it as tens digit, ones digit, terminator,
//               one character per valid/ready handshake.
// Ports       : CLK, RST         - clock, asynchronous active-high reset
//               S[4:0], C5, LOAD - value to send, captured when LOAD & READY
//               READY            - idle, a LOAD will be accepted
//               CHAR[7:0], CHAR_VALID, CHAR_READY - character output channel
// Revision    : 1.0 - initial release
// ============================================================================
module sum_ascii_tx #(
  parameter logic [7:0] EOL_CHAR      = 8'h0A,
  parameter bit         SUPPRESS_ZERO = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] S,
  input  logic       C5,
  input  logic       LOAD,
  output logic       READY,
  output logic [7:0] CHAR,
  output logic       CHAR_VALID,
  input  logic       CHAR_READY
);

  localparam logic [5:0] c_ten       = 6'd10;
  localparam logic [7:0] c_ascii_zero = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_TENS = 3'd2,
    ST_ONES = 3'd3,
    ST_EOL  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] rem_q, rem_d;
  logic [2:0] tens_q, tens_d;
  logic       xfer;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= 6'd0;
      tens_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tens_q  <= tens_d;
    end
  end

  // Moore outputs: decoded purely from the registered state, so an
  // asynchronous reset drops CHAR_VALID without waiting for a clock.
  always_comb begin
    READY      = (state_q == ST_IDLE);
    CHAR_VALID = 1'b0;
    CHAR       = 8'h00;
    case (state_q)
      ST_TENS: begin
        CHAR_VALID = 1'b1;
        CHAR       = c_ascii_zero + {5'd0, tens_q};
      end
      ST_ONES: begin
        CHAR_VALID = 1'b1;
        // After conversion rem_q < 10, so only the low nibble matters.
        CHAR       = c_ascii_zero + {4'd0, rem_q[3:0]};
      end
      ST_EOL: begin
        CHAR_VALID = 1'b1;
        CHAR       = EOL_CHAR;
      end
      default: ;
    endcase
  end

  assign xfer = CHAR_VALID & CHAR_READY;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          rem_d   = {C5, S};
          tens_d  = 3'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // Repeated subtraction: one decimal ten per cycle, at most six.
        if (rem_q >= c_ten) begin
          rem_d  = rem_q - c_ten;
          tens_d = tens_q + 3'd1;
        end else if (SUPPRESS_ZERO && (tens_q == 3'd0)) begin
          state_d = ST_ONES;
        end else begin
          state_d = ST_TENS;
        end
      end
      ST_TENS: if (xfer) state_d = ST_ONES;
      ST_ONES: if (xfer) state_d = ST_EOL;
      ST_EOL:  if (xfer) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_ascii_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sum_ascii_tx
// Description : Directed self-checking bench for sum_ascii_tx. Instance A
//               sends every digit, instance B suppresses a leading zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_ascii_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] s;
  logic       c5;
  logic       load_a, load_b;
  logic       char_ready;
  logic       ready_a, valid_a, ready_b, valid_b;
  logic [7:0] char_a, char_b;

  int total = 0;
  int bad   = 0;

  // results of the last capture
  logic [7:0] got [8];
  int         ngot;
  int         first_v;
  int         rdy_cyc;

  always #5 clk = ~clk;

  sum_ascii_tx #(.EOL_CHAR(8'h0A), .SUPPRESS_ZERO(1'b0)) u_dut_a (
    .CLK(clk), .RST(rst), .S(s), .C5(c5), .LOAD(load_a),
    .READY(ready_a), .CHAR(char_a), .CHAR_VALID(valid_a), .CHAR_READY(char_ready)
  );

  sum_ascii_tx #(.EOL_CHAR(8'h0A), .SUPPRESS_ZERO(1'b1)) u_dut_b (
    .CLK(clk), .RST(rst), .S(s), .C5(c5), .LOAD(load_b),
    .READY(ready_b), .CHAR(char_b), .CHAR_VALID(valid_b), .CHAR_READY(char_ready)
  );

  // Pulse LOAD across one rising edge (cycle 0); returns at the negedge of cycle 1.
  task automatic start(input bit sz, input logic [5:0] v);
    @(negedge clk);
    s = v[4:0]; c5 = v[5];
    if (sz) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0;
    s = 5'($urandom); c5 = 1'($urandom);
  endtask

  // Observe cycles 1.. at each negedge until READY returns, recording
  // transferred characters. Optionally pulses LOAD with load_val in load_at.
  task automatic capture(input bit sz, input int load_at, input logic [5:0] load_val);
    logic v, r;
    logic [7:0] c;
    ngot = 0; first_v = -1; rdy_cyc = -1;
    char_ready = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == load_at) begin
        s = load_val[4:0]; c5 = load_val[5];
        if (sz) load_b = 1'b1; else load_a = 1'b1;
      end else begin
        load_a = 1'b0; load_b = 1'b0;
        s = 5'($urandom); c5 = 1'($urandom);
      end
      v = sz ? valid_b : valid_a;
      r = sz ? ready_b : ready_a;
      c = sz ? char_b  : char_a;
      if (v && first_v < 0) first_v = cyc;
      if (v && char_ready && ngot < 8) begin got[ngot] = c; ngot++; end
      if (r) begin rdy_cyc = cyc; break; end
      @(negedge clk);
    end
    load_a = 1'b0; load_b = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_a = 1'b1; load_b = 1'b1; char_ready = 1'b1;
    s = 5'd13; c5 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a got %b want 1", ready_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got %b want 0", valid_a); end
    total++; if (char_a !== 8'h00) begin bad++; $display("FAIL reset_char_a got %h want 00", char_a); end
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got %b want 0", valid_b); end
    load_a = 1'b0; load_b = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %b want 1", ready_a); end
  endtask

  task automatic test_value13;
    start(1'b0, 6'd13);
    capture(1'b0, 0, 6'd0);
    total++; if (ngot !== 3) begin bad++; $display("FAIL v13_count got %0d want 3", ngot); end
    total++; if (got[0] !== 8'h31 || got[1] !== 8'h33 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL v13_chars got %h %h %h want 31 33 0a", got[0], got[1], got[2]); end
    total++; if (first_v !== 3) begin bad++; $display("FAIL v13_first_valid got %0d want 3", first_v); end
    total++; if (rdy_cyc !== 6) begin bad++; $display("FAIL v13_ready got %0d want 6", rdy_cyc); end
  endtask

  task automatic test_value62;
    start(1'b0, {1'b1, 5'd30});
    capture(1'b0, 0, 6'd0);
    total++; if (ngot !== 3 || got[0] !== 8'h36 || got[1] !== 8'h32 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL v62_chars got n=%0d %h %h %h want 36 32 0a", ngot, got[0], got[1], got[2]); end
    total++; if (first_v !== 8) begin bad++; $display("FAIL v62_first_valid got %0d want 8", first_v); end
    total++; if (rdy_cyc !== 11) begin bad++; $display("FAIL v62_ready got %0d want 11", rdy_cyc); end
  endtask

  task automatic test_value63;
    start(1'b0, 6'd63);
    capture(1'b0, 0, 6'd0);
    total++; if (ngot !== 3 || got[0] !== 8'h36 || got[1] !== 8'h33 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL v63_chars got n=%0d %h %h %h want 36 33 0a", ngot, got[0], got[1], got[2]); end
    total++; if (first_v !== 8) begin bad++; $display("FAIL v63_first_valid got %0d want 8", first_v); end
  endtask

  task automatic test_zero;
    start(1'b0, 6'd0);
    capture(1'b0, 0, 6'd0);
    total++; if (ngot !== 3 || got[0] !== 8'h30 || got[1] !== 8'h30 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL zero_chars got n=%0d %h %h %h want 30 30 0a", ngot, got[0], got[1], got[2]); end
    total++; if (first_v !== 2) begin bad++; $display("FAIL zero_first_valid got %0d want 2", first_v); end
    total++; if (rdy_cyc !== 5) begin bad++; $display("FAIL zero_ready got %0d want 5", rdy_cyc); end
  endtask

  task automatic test_suppress;
    start(1'b1, 6'd7);
    capture(1'b1, 0, 6'd0);
    total++; if (ngot !== 2 || got[0] !== 8'h37 || got[1] !== 8'h0A)
      begin bad++; $display("FAIL sup7_chars got n=%0d %h %h want 37 0a", ngot, got[0], got[1]); end
    total++; if (first_v !== 2) begin bad++; $display("FAIL sup7_first_valid got %0d want 2", first_v); end
    total++; if (rdy_cyc !== 4) begin bad++; $display("FAIL sup7_ready got %0d want 4", rdy_cyc); end
    // Nonzero tens digit is still sent when suppression is enabled.
    start(1'b1, 6'd13);
    capture(1'b1, 0, 6'd0);
    total++; if (ngot !== 3 || got[0] !== 8'h31 || got[1] !== 8'h33 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL sup13_chars got n=%0d %h %h %h want 31 33 0a", ngot, got[0], got[1], got[2]); end
    total++; if (rdy_cyc !== 6) begin bad++; $display("FAIL sup13_ready got %0d want 6", rdy_cyc); end
  endtask

  task automatic test_backpressure;
    int hold;
    int xfers;
    logic [7:0] seq [4];
    hold = 0; xfers = 0;
    start(1'b0, 6'd45);
    char_ready = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (valid_a && char_a == 8'h35 && hold < 5) begin
        char_ready = 1'b0;
        if (hold > 0) begin
          total++; if (valid_a !== 1'b1 || char_a !== 8'h35)
            begin bad++; $display("FAIL bp_hold got v=%b %h want v=1 35", valid_a, char_a); end
        end
        hold++;
      end else begin
        char_ready = 1'b1;
      end
      if (valid_a && char_ready && xfers < 4) begin seq[xfers] = char_a; xfers++; end
      if (ready_a) break;
      @(negedge clk);
    end
    char_ready = 1'b1;
    total++; if (hold !== 5) begin bad++; $display("FAIL bp_hold_cycles got %0d want 5", hold); end
    total++; if (xfers !== 3) begin bad++; $display("FAIL bp_transfers got %0d want 3", xfers); end
    total++; if (seq[0] !== 8'h34 || seq[1] !== 8'h35 || seq[2] !== 8'h0A)
      begin bad++; $display("FAIL bp_chars got %h %h %h want 34 35 0a", seq[0], seq[1], seq[2]); end
  endtask

  task automatic test_busy_load;
    start(1'b0, 6'd21);
    capture(1'b0, 4, 6'd9);
    total++; if (ngot !== 3 || got[0] !== 8'h32 || got[1] !== 8'h31 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL busy_chars got n=%0d %h %h %h want 32 31 0a", ngot, got[0], got[1], got[2]); end
    total++; if (rdy_cyc !== 7) begin bad++; $display("FAIL busy_ready got %0d want 7", rdy_cyc); end
  endtask

  task automatic test_eol_load;
    // LOAD in the cycle the EOL handshake completes must be ignored.
    start(1'b0, 6'd13);
    capture(1'b0, 5, 6'd9);
    total++; if (ngot !== 3 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL eol_chars got n=%0d %h want 3 0a", ngot, got[2]); end
    @(negedge clk);
    total++; if (ready_a !== 1'b1 || valid_a !== 1'b0)
      begin bad++; $display("FAIL eol_load_ignored got ready=%b valid=%b want 1 0", ready_a, valid_a); end
  endtask

  task automatic test_reset_abort;
    start(1'b0, 6'd50);
    @(negedge clk);                  // cycle 2, converting
    rst = 1'b1;
    #1;
    total++; if (ready_a !== 1'b1 || valid_a !== 1'b0)
      begin bad++; $display("FAIL abort_conv got ready=%b valid=%b want 1 0", ready_a, valid_a); end
    @(negedge clk); rst = 1'b0;
    start(1'b0, 6'd3);
    capture(1'b0, 0, 6'd0);
    total++; if (ngot !== 3 || got[0] !== 8'h30 || got[1] !== 8'h33 || got[2] !== 8'h0A)
      begin bad++; $display("FAIL after_abort_chars got n=%0d %h %h %h want 30 33 0a", ngot, got[0], got[1], got[2]); end
    // Reset while a character is offered drops CHAR_VALID without a clock edge.
    start(1'b0, 6'd0);
    @(negedge clk);                  // cycle 2, tens digit offered
    char_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++; if (valid_a !== 1'b0 || char_a !== 8'h00 || ready_a !== 1'b1)
      begin bad++; $display("FAIL async_abort got v=%b c=%h r=%b want 0 00 1", valid_a, char_a, ready_a); end
    @(negedge clk); rst = 1'b0; char_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s = 5'd0; c5 = 1'b0; load_a = 1'b0; load_b = 1'b0; char_ready = 1'b1;
    test_reset();
    test_value13();
    test_value62();
    test_value63();
    test_zero();
    test_suppress();
    test_backpressure();
    test_busy_load();
    test_eol_load();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_ascii_tx.md
# sum_ascii_tx

Transmit side of the calculator's character console: takes the 5-bit sum `S` and carry `C5` produced by the adder (a 6-bit value 0–63), converts it to decimal ASCII and emits it one character per handshake. The frame is tens digit, ones digit, end-of-line, the same two-digits-plus-Enter framing the keyboard side consumes. It sits between the adder output and the character output channel and replaces software-side formatting with hardware.

## Interface
- `EOL_CHAR`, 8'h0A: terminator character sent after the ones digit.
- `SUPPRESS_ZERO`, 0: when 1, the tens digit is not sent if it is 0, giving a 2-character frame.
- `CLK`  input  1: single clock; all state updates on the rising edge.
- `RST`  input  1: asynchronous, active-high reset.
- `S`  input  5: sum bits from the adder; sampled only on an accepted load.
- `C5`  input  1: adder carry-out; forms bit 5 of the value, so value = {C5,S}.
- `LOAD`  input  1: request to start a frame; accepted only when `READY`=1.
- `READY`  output  1: block is idle and will accept `LOAD`.
- `CHAR`  output  8: ASCII character being offered.
- `CHAR_VALID`  output  1: `CHAR` is valid.
- `CHAR_READY`  input  1: consumer accepts `CHAR` this cycle.

## Operation
- The FSM has five states: IDLE, CONV, TENS, ONES, EOL.
- Outputs are Moore outputs decoded from registered state.
  - `READY` = (state==IDLE).
  - `CHAR_VALID` = state ∈ {TENS, ONES, EOL}.
  - `CHAR` = 8'h00 whenever `CHAR_VALID`=0.
- Reset (async, any state):
  - state → IDLE, REM → 0, TENS → 0.
  - Outputs while `RST` is high: `READY`=1, `CHAR_VALID`=0, `CHAR`=8'h00.
  - `LOAD` is ignored while `RST` is high.
- IDLE: on `LOAD`=1, capture REM ← {C5,S} (6 bits) and TENS ← 0 (3 bits), then go to CONV.
- CONV: converts by repeated subtraction, one step per cycle.
  - If REM ≥ 10: REM ← REM − 10, TENS ← TENS + 1, stay in CONV.
  - Otherwise leave CONV: go to ONES if `SUPPRESS_ZERO`=1 and TENS=0, else go to TENS.
  - Width rules: REM stays within 6 bits and never underflows; TENS never exceeds 6.
- TENS: `CHAR` = 8'h30 + TENS. On `CHAR_VALID` & `CHAR_READY`, go to ONES.
- ONES: `CHAR` = 8'h30 + REM[3:0]. On handshake, go to EOL.
- EOL: `CHAR` = `EOL_CHAR`. On handshake, go to IDLE.
- `LOAD` while not IDLE is ignored; no queueing, no corruption of the frame in progress.
- `S`/`C5` changing after capture has no effect on the frame in progress.

## Timing
- Let cycle 0 be the edge at which `LOAD` is accepted, and let t = floor(value/10).
- CONV occupies cycles 1 … t+1.
- First `CHAR_VALID` is asserted in cycle t+2.
  - value 0: cycle 2.
  - value 63: cycle 8.
- With `CHAR_READY` held at 1, one character transfers per cycle.
- `READY` returns in cycle t+5, or t+4 when the tens digit is suppressed.
- Back-pressure: while `CHAR_VALID`=1 and `CHAR_READY`=0, `CHAR` and `CHAR_VALID` hold stable, with no drop and no advance.
- `CHAR_READY` has no effect when `CHAR_VALID`=0.
- `LOAD` in the same cycle the EOL handshake completes is not accepted, because `READY` is still 0 in that cycle. The next frame can start one cycle later.
- `RST` asserted mid-frame: the frame is aborted with no partial completion. `CHAR_VALID` falls asynchronously, and the block restarts in IDLE after `RST` deasserts.

## Test plan
- Drive S=5'd13, C5=0, pulse `LOAD`, hold `CHAR_READY`=1 -> CONV for 2 cycles, then 8'h31, 8'h33, 8'h0A in consecutive cycles; `READY` high again in cycle 6.
- Drive S=5'd30, C5=1 (value 62, adder result of 31+31) -> 8'h36, 8'h32, 8'h0A; first `CHAR_VALID` in cycle 8.
- Drive value 0: with `SUPPRESS_ZERO`=0 -> 8'h30, 8'h30, 8'h0A, first valid in cycle 2; with `SUPPRESS_ZERO`=1 and value 7 -> 8'h37, 8'h0A only.
- Back-pressure: value 45, drop `CHAR_READY` for 5 cycles while the ones digit is offered -> `CHAR`=8'h35 and `CHAR_VALID`=1 stable throughout, then 8'h0A; exactly 3 transfers total.
- Pulse `LOAD` with value 9 while a frame with value 21 is in TENS -> output stream remains 8'h32, 8'h31, 8'h0A; value 9 is never emitted.
- Assert `RST` during CONV of value 50 -> `CHAR_VALID`=0 and `READY`=1 immediately; after release, a new `LOAD` of value 3 yields 8'h30, 8'h33, 8'h0A.
